jk_cmd_conditioner: RTL and testbench

Input conditioner that sits directly upstream of the team's JK flip-flop. It synchronizes and debounces two raw asynchronous command inputs, SET_IN and CLR_IN. It converts their debounced rising edges into registered single-cycle J/K pulses. Near-simultaneous set and clear requests, arriving within a programmable pairing window, are merged into one J=K=1 toggle pulse. J and K connect straight to the flip-flop's J/K pins on the same CLK.

---
 rtl/jk_cmd_conditioner.sv | 152 +++++++++++++++
 tb/tb_jk_cmd_conditioner.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/jk_cmd_conditioner.sv
// Purpose : sync + debounce SET_IN/CLR_IN, turn debounced rises into one-cycle J/K pulses,
//           merging set/clear rises that land within PAIR_WIN cycles into a J=K=1 toggle.
// Latency : raw edge to J/K is 2+DEBOUNCE_CYCLES cycles (lone, PAIR_WIN=0), +PAIR_WIN when waiting.
// Backpr. : none; this is a free-running conditioner and every qualified edge is consumed.
module jk_cmd_conditioner #(
   parameter int DEBOUNCE_CYCLES = 4,
   parameter int PAIR_WIN        = 3
) (
   input  logic CLK,
   input  logic RST,
   input  logic SET_IN,
   input  logic CLR_IN,
   output logic J,
   output logic K,
   output logic SET_LVL,
   output logic CLR_LVL,
   output logic PENDING
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   // Keep the timer at least one bit wide so PAIR_WIN=0 still elaborates.
   localparam int TW = (PAIR_WIN > 0) ? $clog2(PAIR_WIN + 1) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [TW-1:0] TMR_LAST = TW'(PAIR_WIN - 1);

   typedef enum logic [1:0] {IDLE, PEND_SET, PEND_CLR} state_t;

   // Channel index 0 is SET, 1 is CLR.
   logic [1:0]    s1_q, s2_q;
   logic [1:0]    lvl_q, lvl_d;
   logic [1:0]    lvl_dly_q;
   logic [CW-1:0] cnt_q [2];
   logic [CW-1:0] cnt_d [2];
   logic [1:0]    rise;
   state_t        state_q;
   logic [TW-1:0] tmr_q;

   // Two-flop synchronizer for both raw inputs.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         s1_q <= {CLR_IN, SET_IN};
         s2_q <= s1_q;
      end
   end

   // Debounce: the level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
   always_comb begin
      for (int c = 0; c < 2; c++) begin
         lvl_d[c] = lvl_q[c];
         cnt_d[c] = cnt_q[c];
         if (s2_q[c] == lvl_q[c]) begin
            cnt_d[c] = '0;
         end else if (cnt_q[c] == CNT_LAST) begin
            lvl_d[c] = s2_q[c];
            cnt_d[c] = '0;
         end else begin
            cnt_d[c] = cnt_q[c] + 1'b1;
         end
      end
   end

   // Debounce state and delayed level copy used for rise detection.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         lvl_q     <= '0;
         lvl_dly_q <= '0;
         for (int c = 0; c < 2; c++) cnt_q[c] <= '0;
      end else begin
         lvl_q     <= lvl_d;
         lvl_dly_q <= lvl_q;
         for (int c = 0; c < 2; c++) cnt_q[c] <= cnt_d[c];
      end
   end

   assign rise    = lvl_q & ~lvl_dly_q;
   assign SET_LVL = lvl_q[0];
   assign CLR_LVL = lvl_q[1];

   // Pairing FSM with registered J/K/PENDING; a repeat rise of the held channel is absorbed.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q <= IDLE;
         tmr_q   <= '0;
         J       <= 1'b0;
         K       <= 1'b0;
         PENDING <= 1'b0;
      end else begin
         J <= 1'b0;
         K <= 1'b0;
         case (state_q)
            IDLE: begin
               if (rise[0] && rise[1]) begin
                  J <= 1'b1;
                  K <= 1'b1;
               end else if (rise[0]) begin
                  if (PAIR_WIN == 0) begin
                     J <= 1'b1;
                  end else begin
                     state_q <= PEND_SET;
                     tmr_q   <= '0;
                     PENDING <= 1'b1;
                  end
               end else if (rise[1]) begin
                  if (PAIR_WIN == 0) begin
                     K <= 1'b1;
                  end else begin
                     state_q <= PEND_CLR;
                     tmr_q   <= '0;
                     PENDING <= 1'b1;
                  end
               end
            end
            PEND_SET: begin
               if (rise[1]) begin
                  J       <= 1'b1;
                  K       <= 1'b1;
                  state_q <= IDLE;
                  PENDING <= 1'b0;
               end else if (tmr_q == TMR_LAST) begin
                  J       <= 1'b1;
                  state_q <= IDLE;
                  PENDING <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            PEND_CLR: begin
               if (rise[0]) begin
                  J       <= 1'b1;
                  K       <= 1'b1;
                  state_q <= IDLE;
                  PENDING <= 1'b0;
               end else if (tmr_q == TMR_LAST) begin
                  K       <= 1'b1;
                  state_q <= IDLE;
                  PENDING <= 1'b0;
               end else begin
                  tmr_q <= tmr_q + 1'b1;
               end
            end
            default: begin
               state_q <= IDLE;
               PENDING <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_jk_cmd_conditioner.sv
// Bench for jk_cmd_conditioner: three parameterisations driven by shared inputs,
// an event-level reference model compared every cycle, plus literal timing pins.
module tb_jk_cmd_conditioner;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   logic SET_IN = 1'b0;
   logic CLR_IN = 1'b0;
   logic [2:0] dj, dk, dsl, dcl, dp;

   always #5 CLK = ~CLK;

   jk_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .PAIR_WIN(0)) dut0 (
      .CLK(CLK), .RST(RST), .SET_IN(SET_IN), .CLR_IN(CLR_IN),
      .J(dj[0]), .K(dk[0]), .SET_LVL(dsl[0]), .CLR_LVL(dcl[0]), .PENDING(dp[0]));
   jk_cmd_conditioner #(.DEBOUNCE_CYCLES(4), .PAIR_WIN(3)) dut1 (
      .CLK(CLK), .RST(RST), .SET_IN(SET_IN), .CLR_IN(CLR_IN),
      .J(dj[1]), .K(dk[1]), .SET_LVL(dsl[1]), .CLR_LVL(dcl[1]), .PENDING(dp[1]));
   jk_cmd_conditioner #(.DEBOUNCE_CYCLES(1), .PAIR_WIN(1)) dut2 (
      .CLK(CLK), .RST(RST), .SET_IN(SET_IN), .CLR_IN(CLR_IN),
      .J(dj[2]), .K(dk[2]), .SET_LVL(dsl[2]), .CLR_LVL(dcl[2]), .PENDING(dp[2]));

   int DP [3] = '{4, 4, 1};
   int WP [3] = '{0, 3, 1};

   int errors = 0;
   int checks = 0;

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s got=%0d want=%0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Debounced level flips when the last D synchronized samples all differ from it.
   // A pending edge times out exactly W edges after it was taken.
   int ec;                  // functional edges since reset release
   bit m_s1 [2], m_s2 [2];
   bit hq_s[$], hq_c[$];    // synchronized samples seen per edge
   bit mlvl [3][2], mprev [3][2];
   int pend [3];            // 0 none, 1 holding set, 2 holding clear
   int pstart [3];
   bit eJ [3], eK [3];

   function automatic bit window_flips(input int c, input int d, input bit lv);
      int n;
      n = (c == 0) ? hq_s.size() : hq_c.size();
      if (n < d) return 1'b0;
      for (int k = n - d; k < n; k++)
         if (((c == 0) ? hq_s[k] : hq_c[k]) == lv) return 1'b0;
      return 1'b1;
   endfunction

   always @(posedge CLK or negedge RST) begin
      if (!RST) begin
         ec = 0;
         hq_s.delete();
         hq_c.delete();
         for (int c = 0; c < 2; c++) begin m_s1[c] = 0; m_s2[c] = 0; end
         for (int i = 0; i < 3; i++) begin
            for (int c = 0; c < 2; c++) begin mlvl[i][c] = 0; mprev[i][c] = 0; end
            pend[i] = 0; pstart[i] = 0; eJ[i] = 0; eK[i] = 0;
         end
      end else begin
         ec = ec + 1;
         hq_s.push_back(m_s2[0]);
         hq_c.push_back(m_s2[1]);
         if (hq_s.size() > 300) begin void'(hq_s.pop_front()); void'(hq_c.pop_front()); end
         m_s2[0] = m_s1[0]; m_s2[1] = m_s1[1];
         m_s1[0] = SET_IN;  m_s1[1] = CLR_IN;
         for (int i = 0; i < 3; i++) begin
            bit rs, rc;
            rs = mlvl[i][0] && !mprev[i][0];
            rc = mlvl[i][1] && !mprev[i][1];
            eJ[i] = 0; eK[i] = 0;
            if (pend[i] == 0) begin
               if (rs && rc) begin eJ[i] = 1; eK[i] = 1; end
               else if (rs) begin
                  if (WP[i] == 0) eJ[i] = 1; else begin pend[i] = 1; pstart[i] = ec; end
               end else if (rc) begin
                  if (WP[i] == 0) eK[i] = 1; else begin pend[i] = 2; pstart[i] = ec; end
               end
            end else begin
               if ((pend[i] == 1 && rc) || (pend[i] == 2 && rs)) begin
                  eJ[i] = 1; eK[i] = 1; pend[i] = 0;
               end else if (ec - pstart[i] == WP[i]) begin
                  if (pend[i] == 1) eJ[i] = 1; else eK[i] = 1;
                  pend[i] = 0;
               end
            end
            for (int c = 0; c < 2; c++) begin
               mprev[i][c] = mlvl[i][c];
               if (window_flips(c, DP[i], mlvl[i][c])) mlvl[i][c] = !mlvl[i][c];
            end
         end
      end
   end

   // Compare every DUT output against the model on each falling edge.
   always @(negedge CLK) begin
      for (int i = 0; i < 3; i++) begin
         check($sformatf("J[%0d]", i), int'(dj[i]), int'(eJ[i]));
         check($sformatf("K[%0d]", i), int'(dk[i]), int'(eK[i]));
         check($sformatf("SET_LVL[%0d]", i), int'(dsl[i]), int'(mlvl[i][0]));
         check($sformatf("CLR_LVL[%0d]", i), int'(dcl[i]), int'(mlvl[i][1]));
         check($sformatf("PENDING[%0d]", i), int'(dp[i]), int'(pend[i] != 0));
      end
   end

   // ---------------- event recorder for literal pins ----------------
   int jfirst [3], kfirst [3], pfirst [3], lfirst [3];
   int jcnt [3], kcnt [3], pcnt [3];

   always @(negedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 3; i++) begin
            if (dj[i])  begin jcnt[i]++; if (jfirst[i] < 0) jfirst[i] = ec; end
            if (dk[i])  begin kcnt[i]++; if (kfirst[i] < 0) kfirst[i] = ec; end
            if (dp[i])  begin pcnt[i]++; if (pfirst[i] < 0) pfirst[i] = ec; end
            if (dsl[i] && lfirst[i] < 0) lfirst[i] = ec;
         end
      end
   end

   task automatic arm();
      for (int i = 0; i < 3; i++) begin
         jfirst[i] = -1; kfirst[i] = -1; pfirst[i] = -1; lfirst[i] = -1;
         jcnt[i] = 0; kcnt[i] = 0; pcnt[i] = 0;
      end
   endtask

   task automatic do_reset(input int n);
      @(negedge CLK);
      #2 RST = 1'b0;
      #1 check("rst_outputs", int'({dj, dk, dsl, dcl, dp}), 0);
      repeat (n) @(negedge CLK);
      RST = 1'b1;
      arm();
   endtask

   task automatic wait_ec(input int e);
      int g;
      g = 0;
      while (ec < e && g < 2000) begin @(negedge CLK); g++; end
      if (ec < e) check("wait_timeout", ec, e);
   endtask

   initial begin
      #1 RST = 1'b0;
      arm();

      // Lone set, held high from edge 10.
      do_reset(3);
      wait_ec(9);  SET_IN = 1'b1;
      wait_ec(30);
      check("lone_lvl_edge_d4", lfirst[0], 15);
      check("lone_J_edge_w0", jfirst[0], 16);
      check("lone_J_count_w0", jcnt[0], 1);
      check("lone_K_count_w0", kcnt[0], 0);
      check("timeout_pend_edge_w3", pfirst[1], 16);
      check("timeout_pend_cycles_w3", pcnt[1], 3);
      check("timeout_J_edge_w3", jfirst[1], 19);
      check("timeout_K_none_w3", kcnt[1], 0);
      check("lone_J_edge_d1w1", jfirst[2], 14);
      // A later clear edge gets its own K pulse.
      CLR_IN = 1'b1;
      wait_ec(45);
      check("late_clr_K_w3", kcnt[1], 1);
      check("late_clr_J_still1_w3", jcnt[1], 1);
      SET_IN = 1'b0; CLR_IN = 1'b0;

      // Pairing: set at edge 10, clear at edge 11.
      do_reset(2);
      wait_ec(9);  SET_IN = 1'b1;
      wait_ec(10); CLR_IN = 1'b1;
      wait_ec(30);
      check("pair_pend_edge", pfirst[1], 16);
      check("pair_J_edge", jfirst[1], 17);
      check("pair_K_edge", kfirst[1], 17);
      check("pair_J_count", jcnt[1], 1);
      check("pair_pend_cycles", pcnt[1], 1);
      check("pair_w0_K_edge", kfirst[0], 17);
      SET_IN = 1'b0; CLR_IN = 1'b0;

      // Simultaneous rises.
      do_reset(2);
      wait_ec(9);  SET_IN = 1'b1; CLR_IN = 1'b1;
      wait_ec(30);
      check("simul_J_edge", jfirst[1], 16);
      check("simul_K_edge", kfirst[1], 16);
      check("simul_no_pending", pcnt[1], 0);
      SET_IN = 1'b0; CLR_IN = 1'b0;

      // Glitch of 3 samples rejected, 4 samples accepted.
      do_reset(2);
      wait_ec(9);  SET_IN = 1'b1;
      wait_ec(12); SET_IN = 1'b0;
      wait_ec(19);
      check("glitch3_no_lvl", lfirst[0], -1);
      check("glitch3_no_J", jcnt[0], 0);
      SET_IN = 1'b1;
      wait_ec(23); SET_IN = 1'b0;
      wait_ec(40);
      check("steady4_lvl_edge", lfirst[0], 25);
      check("steady4_J_count", jcnt[0], 1);

      // Reset asserted while holding a set edge.
      do_reset(2);
      wait_ec(9);  SET_IN = 1'b1;
      wait_ec(16);
      check("midwait_pending", int'(dp[1]), 1);
      #2 RST = 1'b0;
      #1 check("midwait_async_clear", int'({dp[1], dsl[1], dj[1], dk[1]}), 0);
      repeat (2) @(negedge CLK);
      RST = 1'b1;
      arm();
      wait_ec(20);
      check("replay_J_edge_w0", jfirst[0], 7);
      check("replay_J_edge_w3", jfirst[1], 10);
      check("replay_J_count_w3", jcnt[1], 1);
      SET_IN = 1'b0;

      // Randomized traffic with alternating slow/fast toggle rates and occasional resets.
      do_reset(2);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         int rate;
         @(negedge CLK);
         rate = ((cyc / 500) % 2 == 1) ? 3 : 12;
         if ($urandom_range(0, rate - 1) == 0) SET_IN = ~SET_IN;
         if ($urandom_range(0, rate - 1) == 0) CLR_IN = ~CLR_IN;
         if ($urandom_range(0, 599) == 0) begin
            #2 RST = 1'b0;
            @(negedge CLK);
            RST = 1'b1;
         end
      end
      @(negedge CLK);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=%0d want=0", 1);
      $fatal(1, "watchdog");
   end

endmodule
